// File: rtl/spi_txf_ctrl.sv
// Transmit FIFO feeding the SPI shifter, with underflow/overflow event pulses.
// Optional underflow counter (ufcnt_o) is built when SPI_TXF_UFCNT_EN is defined.
module spi_txf_ctrl #(
    parameter int DW    = 8,
    parameter int Depth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    input  logic [DW-1:0]              wdata_i,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [DW-1:0]              rdata_o,
    output logic [$clog2(Depth):0]     depth_o,
    output logic                       txunderflow_o,
    output logic                       txoverflow_o
`ifdef SPI_TXF_UFCNT_EN
    ,
    output logic [7:0]                 ufcnt_o
`endif
);

    localparam int AW = $clog2(Depth);

    logic [DW-1:0] r_mem [Depth];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_uf;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;
    logic          w_uf;
    logic          w_ovf;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_empty = (r_wptr == r_rptr);

    assign w_wr  = wvalid_i && !w_full  && !clr_i;
    assign w_rd  = rready_i && !w_empty && !clr_i;
    assign w_uf  = rready_i &&  w_empty && !clr_i;
    assign w_ovf = wvalid_i &&  w_full  && !clr_i;

    assign wready_o      = !w_full;
    assign rvalid_o      = !w_empty;
    assign rdata_o       = w_empty ? {DW{1'b1}} : r_mem[r_rptr[AW-1:0]];
    assign depth_o       = r_wptr - r_rptr;
    assign txunderflow_o = r_uf;
    assign txoverflow_o  = r_ovf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_uf   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_uf  <= w_uf;
            r_ovf <= w_ovf;
            if (clr_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr) r_wptr <= r_wptr + 1'b1;
                if (w_rd) r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata_i;
    end

`ifdef SPI_TXF_UFCNT_EN
    logic [7:0] r_ufcnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ufcnt <= 8'h00;
        end else if (clr_i) begin
            r_ufcnt <= 8'h00;
        end else if (w_uf && (r_ufcnt != 8'hFF)) begin
            r_ufcnt <= r_ufcnt + 8'h01;
        end
    end

    assign ufcnt_o = r_ufcnt;
`endif

endmodule

// File: tb/tb_spi_txf_ctrl.sv
// Directed self-checking bench for spi_txf_ctrl (DW=8, Depth=16).
module tb_spi_txf_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clr_i;
    logic       wvalid_i;
    logic       wready_o;
    logic [7:0] wdata_i;
    logic       rvalid_o;
    logic       rready_i;
    logic [7:0] rdata_o;
    logic [4:0] depth_o;
    logic       txunderflow_o;
    logic       txoverflow_o;
`ifdef SPI_TXF_UFCNT_EN
    logic [7:0] ufcnt_o;
`endif

    int checks = 0;
    int errors = 0;

    spi_txf_ctrl #(.DW(8), .Depth(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clr_i         (clr_i),
        .wvalid_i      (wvalid_i),
        .wready_o      (wready_o),
        .wdata_i       (wdata_i),
        .rvalid_o      (rvalid_o),
        .rready_i      (rready_i),
        .rdata_o       (rdata_o),
        .depth_o       (depth_o),
        .txunderflow_o (txunderflow_o),
        .txoverflow_o  (txoverflow_o)
`ifdef SPI_TXF_UFCNT_EN
        ,
        .ufcnt_o       (ufcnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wvalid_i = 1'b0;
        rready_i = 1'b0;
        clr_i    = 1'b0;
        wdata_i  = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        #3;
        checks++; if (wready_o !== 1'b1) begin errors++; $display("FAIL reset_wready got %b exp 1", wready_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid_o); end
        checks++; if (rdata_o !== 8'hFF) begin errors++; $display("FAIL reset_rdata got %h exp ff", rdata_o); end
        checks++; if (depth_o !== 5'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth_o); end
        checks++; if ({txunderflow_o, txoverflow_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {txunderflow_o, txoverflow_o}); end
`ifdef SPI_TXF_UFCNT_EN
        checks++; if (ufcnt_o !== 8'h00) begin errors++; $display("FAIL reset_ufcnt got %h exp 00", ufcnt_o); end
`endif
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        wvalid_i = 1'b1;
        wdata_i  = 8'hA5;
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL no_fallthrough got %b exp 0", rvalid_o); end
        tick();
        idle();
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL single_rvalid got %b exp 1", rvalid_o); end
        checks++; if (rdata_o !== 8'hA5) begin errors++; $display("FAIL single_rdata got %h exp a5", rdata_o); end
        checks++; if (depth_o !== 5'd1) begin errors++; $display("FAIL single_depth got %0d exp 1", depth_o); end
        rready_i = 1'b1;
        tick();
        idle();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL single_drain_rvalid got %b exp 0", rvalid_o); end
        checks++; if (rdata_o !== 8'hFF) begin errors++; $display("FAIL single_drain_rdata got %h exp ff", rdata_o); end
        checks++; if (txunderflow_o !== 1'b0) begin errors++; $display("FAIL single_no_uf got %b exp 0", txunderflow_o); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            wvalid_i = 1'b1;
            wdata_i  = 8'(i);
            tick();
        end
        checks++; if (wready_o !== 1'b0) begin errors++; $display("FAIL full_wready got %b exp 0", wready_o); end
        checks++; if (depth_o !== 5'd16) begin errors++; $display("FAIL full_depth got %0d exp 16", depth_o); end
        checks++; if (txoverflow_o !== 1'b0) begin errors++; $display("FAIL full_no_ovf_yet got %b exp 0", txoverflow_o); end
        wdata_i = 8'h10;
        tick();
        idle();
        checks++; if (txoverflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", txoverflow_o); end
        checks++; if (depth_o !== 5'd16) begin errors++; $display("FAIL ovf_depth got %0d exp 16", depth_o); end
        tick();
        checks++; if (txoverflow_o !== 1'b0) begin errors++; $display("FAIL ovf_once got %b exp 0", txoverflow_o); end
        checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL ovf_head got %h exp 00", rdata_o); end
    endtask

    task automatic test_full_rw();
        wvalid_i = 1'b1;
        wdata_i  = 8'h77;
        rready_i = 1'b1;
        tick();
        idle();
        checks++; if (depth_o !== 5'd15) begin errors++; $display("FAIL full_rw_depth got %0d exp 15", depth_o); end
        checks++; if (rdata_o !== 8'h01) begin errors++; $display("FAIL full_rw_head got %h exp 01", rdata_o); end
        checks++; if (wready_o !== 1'b1) begin errors++; $display("FAIL full_rw_wready got %b exp 1", wready_o); end
        for (int i = 1; i < 16; i++) begin
            checks++; if (rdata_o !== 8'(i)) begin errors++; $display("FAIL drain_order got %h exp %h", rdata_o, 8'(i)); end
            rready_i = 1'b1;
            tick();
        end
        idle();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", rvalid_o); end
        checks++; if (txunderflow_o !== 1'b0) begin errors++; $display("FAIL drain_no_uf got %b exp 0", txunderflow_o); end
    endtask

    task automatic test_underflow();
        rready_i = 1'b1;
        checks++; if (rdata_o !== 8'hFF) begin errors++; $display("FAIL uf_rdata got %h exp ff", rdata_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (txunderflow_o !== 1'b1) begin errors++; $display("FAIL uf_pulse cycle %0d got %b exp 1", i, txunderflow_o); end
        end
        idle();
        tick();
        checks++; if (txunderflow_o !== 1'b0) begin errors++; $display("FAIL uf_end got %b exp 0", txunderflow_o); end
`ifdef SPI_TXF_UFCNT_EN
        checks++; if (ufcnt_o !== 8'd3) begin errors++; $display("FAIL ufcnt_3 got %0d exp 3", ufcnt_o); end
`endif
    endtask

    task automatic test_empty_rw();
        wvalid_i = 1'b1;
        wdata_i  = 8'h3C;
        rready_i = 1'b1;
        checks++; if (rdata_o !== 8'hFF) begin errors++; $display("FAIL erw_rdata_now got %h exp ff", rdata_o); end
        tick();
        idle();
        checks++; if (txunderflow_o !== 1'b1) begin errors++; $display("FAIL erw_uf got %b exp 1", txunderflow_o); end
        checks++; if (depth_o !== 5'd1) begin errors++; $display("FAIL erw_depth got %0d exp 1", depth_o); end
        checks++; if (rdata_o !== 8'h3C) begin errors++; $display("FAIL erw_rdata got %h exp 3c", rdata_o); end
        // Steady state: simultaneous read and write keeps occupancy.
        wvalid_i = 1'b1;
        wdata_i  = 8'h4D;
        rready_i = 1'b1;
        tick();
        idle();
        checks++; if (depth_o !== 5'd1) begin errors++; $display("FAIL mid_rw_depth got %0d exp 1", depth_o); end
        checks++; if (rdata_o !== 8'h4D) begin errors++; $display("FAIL mid_rw_rdata got %h exp 4d", rdata_o); end
        rready_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) begin
            wvalid_i = 1'b1;
            wdata_i  = 8'h20 + 8'(i);
            tick();
        end
        idle();
        checks++; if (depth_o !== 5'd5) begin errors++; $display("FAIL clr_pre_depth got %0d exp 5", depth_o); end
        clr_i    = 1'b1;
        rready_i = 1'b1;
        tick();
        idle();
        checks++; if (depth_o !== 5'd0) begin errors++; $display("FAIL clr_depth got %0d exp 0", depth_o); end
        checks++; if (txunderflow_o !== 1'b0) begin errors++; $display("FAIL clr_no_uf got %b exp 0", txunderflow_o); end
        clr_i    = 1'b1;
        rready_i = 1'b1;
        tick();
        idle();
        checks++; if (txunderflow_o !== 1'b0) begin errors++; $display("FAIL clr_empty_no_uf got %b exp 0", txunderflow_o); end
`ifdef SPI_TXF_UFCNT_EN
        checks++; if (ufcnt_o !== 8'h00) begin errors++; $display("FAIL clr_ufcnt got %h exp 00", ufcnt_o); end
        rready_i = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        idle();
        checks++; if (ufcnt_o !== 8'hFF) begin errors++; $display("FAIL ufcnt_sat got %h exp ff", ufcnt_o); end
        clr_i = 1'b1;
        tick();
        idle();
        checks++; if (ufcnt_o !== 8'h00) begin errors++; $display("FAIL ufcnt_clr got %h exp 00", ufcnt_o); end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            wvalid_i = 1'b1;
            wdata_i  = 8'h50 + 8'(i);
            tick();
        end
        checks++; if (depth_o !== 5'd3) begin errors++; $display("FAIL mid_pre_depth got %0d exp 3", depth_o); end
        rready_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (depth_o !== 5'd0) begin errors++; $display("FAIL mid_rst_depth got %0d exp 0", depth_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid got %b exp 0", rvalid_o); end
        checks++; if (wready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_wready got %b exp 1", wready_o); end
        checks++; if (rdata_o !== 8'hFF) begin errors++; $display("FAIL mid_rst_rdata got %h exp ff", rdata_o); end
        idle();
        tick();
        checks++; if ({txunderflow_o, txoverflow_o} !== 2'b00) begin errors++; $display("FAIL mid_rst_pulses got %b exp 00", {txunderflow_o, txoverflow_o}); end
        rst_ni = 1'b1;
        tick();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL post_rst_empty got %b exp 0", rvalid_o); end
        checks++; if (depth_o !== 5'd0) begin errors++; $display("FAIL post_rst_depth got %0d exp 0", depth_o); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_empty_rw();
        test_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
